fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage sitting directly upstream of the instruction decoder. Holds the fetch PC, issues word requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a small in-order FIFO. It presents each instruction with its PC to the decode stage. A redirect from branch resolution or trap entry/return (ECALL, MRET, illegal-instruction trap) flushes everything in flight and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, FIFO entries and maximum in-flight requests; power of two, ≥2.

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0
- imem_req_valid  out  1  request pending
- imem_req_addr  out  32  word address of request (current fetch PC)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  one response word returned
- imem_resp_data  in  32  instruction word; responses arrive in request order, ≥1 cycle after acceptance
- dec_valid  out  1  FIFO head valid
- dec_inst  out  32  instruction at FIFO head
- dec_pc  out  32  PC of dec_inst
- dec_ready  in  1  decode consumes head this cycle

## Operation
- State: fetch_pc (32b), FIFO of DEPTH {pc, inst} entries, outstanding counter (in-flight accepted requests, clog2(DEPTH)+1 bits), drop counter (same width).
- Credit rule: imem_req_valid = !redirect_valid && (outstanding + fifo_count < DEPTH). This guarantees every response has a FIFO slot; no response is ever lost or back-pressured.
- imem_req_addr = fetch_pc whenever imem_req_valid=1. Once asserted, valid and addr hold until accepted, or until a redirect retracts them.
- Accept (valid && ready): fetch_pc += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). outstanding++. A FIFO-side request PC record is kept in order alongside the request.
- Response with drop_cnt==0: enqueue {pc of oldest in-flight request, imem_resp_data}; outstanding--.
- Response with drop_cnt>0: discard; drop_cnt--; outstanding--.
- Dequeue (dec_valid && dec_ready): pop head. Enqueue and dequeue in the same cycle are both honoured.
- Redirect (redirect_valid=1) has priority over everything else that cycle:
  - fetch_pc ← {redirect_pc[31:2],2'b00};
  - FIFO emptied;
  - dec_ready in that cycle is ignored;
  - drop_cnt ← outstanding minus 1 if a response arrives that same cycle (that response is also discarded), else outstanding;
  - no request is accepted that cycle.
- Redirect while drop_cnt>0 adds the current non-dropped in-flight count; all older responses stay discarded.
- Fetch stalls are permitted; the stage never reorders or duplicates instructions.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC;
  - dec_valid=0, dec_inst=0, dec_pc=0;
  - fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty.
- First cycle after rst_n deasserts: imem_req_valid=1, imem_req_addr=RESET_PC.
- Latency: response in cycle N → dec_valid=1 in cycle N+1 (registered FIFO, no bypass).
- Steady state with single-cycle memory and dec_ready=1: one instruction per cycle.
- Redirect in cycle N:
  - dec_valid=0 in cycle N+1;
  - imem_req_valid=1 with addr=redirect_pc in N+1, provided credit allows;
  - first post-redirect instruction no earlier than N+3.
- rst_n asserted mid-operation: immediate return to reset values. Memory responses from before reset are not tracked; the memory must also be reset.
- FIFO full with dec_ready=0: imem_req_valid=0 until a dequeue frees credit.

## Test plan
- Reset then run: RESET_PC=0x100, memory latency 1, dec_ready=1 → dec_pc sequence 0x100, 0x104, 0x108…; dec_valid rises 2 cycles after first request accepted.
- Back-pressure: dec_ready=0 for 10 cycles, DEPTH=2 → exactly 2 requests accepted, FIFO holds 0x100/0x104, imem_req_valid=0; release → both delivered in order, then fetch resumes at 0x108.
- Redirect with in-flight: latency 3, 2 outstanding, redirect_pc=0x2002 → both old responses dropped, next dec_pc=0x2000, then 0x2004; no stale instruction reaches decode.
- Redirect coincident with response and dequeue in the same cycle → response discarded, head not popped twice, dec_valid=0 next cycle, drop_cnt correct (remaining in-flight only).
- Wrap: redirect_pc=0xFFFF_FFF8 → dec_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset asserted mid-stream with dec_valid=1 → dec_valid and imem_req_valid go 0 without a clock edge; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the fetch PC, issues word requests to
// instruction memory under a credit limit, and buffers the returned
// instructions in an in-order FIFO that feeds the decoder.
// A redirect flushes the FIFO and marks in-flight responses for discard.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   redirect_valid/redirect_pc       flush and restart fetch at redirect_pc
//   imem_req_valid/addr/ready        request handshake to instruction memory
//   imem_resp_valid/data             in-order response words
//   dec_valid/inst/pc/ready          FIFO head presented to decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] rhead_q, rhead_d, rtail_q, rtail_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   rec_pc_q    [DEPTH];

  logic credit, accept, drop_now, keep, deq;
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Issue only while every possible response already has a FIFO slot.
  assign credit         = (SW'(out_q) + SW'(cnt_q)) < SW'(DEPTH);
  assign imem_req_valid = run_q & ~redirect_valid & credit;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign drop_now  = (drop_q != '0);
  assign keep      = imem_resp_valid & ~drop_now & ~redirect_valid;
  assign dec_valid = (cnt_q != '0);
  assign deq       = dec_valid & dec_ready & ~redirect_valid;
  assign dec_inst  = fifo_inst_q[head_q];
  assign dec_pc    = fifo_pc_q[head_q];

  // Next-state: counters, pointers and fetch PC; redirect overrides all.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + CW'(accept) - CW'(imem_resp_valid);
    drop_d     = drop_q;
    cnt_d      = cnt_q + CW'(keep) - CW'(deq);
    head_d     = head_q + AW'(deq);
    tail_d     = tail_q + AW'(keep);
    rhead_d    = rhead_q + AW'(imem_resp_valid);
    rtail_d    = rtail_q + AW'(accept);
    if (drop_now && imem_resp_valid) begin
      drop_d = drop_q - CW'(1'b1);
    end
    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // Everything still in flight after this cycle is stale.
      drop_d     = out_q - CW'(imem_resp_valid);
      cnt_d      = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  // State registers and storage arrays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rhead_q    <= '0;
      rtail_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
        rec_pc_q[i]    <= '0;
      end
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rhead_q    <= rhead_d;
      rtail_q    <= rtail_d;
      // Request PC record: one entry per in-flight request, retired by its response.
      if (accept) begin
        rec_pc_q[rtail_q] <= fetch_pc_q;
      end
      if (keep) begin
        fifo_pc_q[tail_q]   <= rec_pc_q[rhead_q];
        fifo_inst_q[tail_q] <= imem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: memory model with configurable latency, a
// scoreboard of expected {pc, inst} per fetch epoch, and a monitor that
// compares every instruction handed to decode.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;

  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  int          n_cmp;
  int          n_fail;
  int          n_deliv;
  int          cyc;
  int          last_due;
  int          lat_cfg;
  logic [31:0] model_pc;
  logic [31:0] prev_addr;
  logic [31:0] last_acc_addr;
  bit          prev_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, observe handshakes before posedge.
  // mode 0: no redirect, 1: redirect, 2: redirect only if a response meets a valid head.
  task automatic step(input int mode, input logic [31:0] rpc, input bit rdy, input bit drdy,
                      output bit did_redir, output bit dv, output bit acc);
    bit   resp_fire;
    int   lat;
    int   due;
    pend_t p;
    @(negedge clk);
    cyc++;
    resp_fire = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    did_redir = (mode == 1) || (mode == 2 && resp_fire && dec_valid);
    imem_resp_valid = resp_fire;
    imem_resp_data  = resp_fire ? pend_q[0].data : $urandom;
    redirect_valid  = did_redir;
    redirect_pc     = did_redir ? rpc : $urandom;
    imem_req_ready  = rdy;
    dec_ready       = drdy;
    #2;
    dv  = dec_valid;
    acc = imem_req_valid && rdy;
    if (prev_stall && !did_redir) begin
      check("req_hold_valid", 32'(imem_req_valid), 32'd1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (did_redir) begin
      check("redirect_no_req", 32'(imem_req_valid), 32'd0);
      model_pc = {rpc[31:2], 2'b00};
      exp_q.delete();
    end
    if (acc) begin
      check("req_addr", imem_req_addr, model_pc);
      exp_q.push_back('{pc: model_pc, inst: memfn(model_pc)});
      lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      p.data = memfn(imem_req_addr);
      p.due  = due;
      pend_q.push_back(p);
      last_acc_addr = imem_req_addr;
      model_pc = model_pc + 32'd4;
    end
    if (resp_fire) void'(pend_q.pop_front());
    prev_stall = imem_req_valid && !rdy && !did_redir;
    prev_addr  = imem_req_addr;
  endtask

  // Asynchronous reset between clock edges; outputs must drop immediately.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    check("rst_dec_inst", dec_inst, 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    exp_q.delete();
    pend_q.delete();
    model_pc   = RST_PC;
    last_due   = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every decode handshake pops and checks one expected instruction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && dec_valid && dec_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h inst %h, nothing expected", dec_pc, dec_inst);
        end else begin
          e = exp_q.pop_front();
          check("dec_pc", dec_pc, e.pc);
          check("dec_inst", dec_inst, e.inst);
          n_deliv++;
        end
      end
    end
  end

  initial begin : stim
    bit dr, dv, acc;
    int first_acc, first_dv, n_acc, base, fk;
    bit found;
    n_cmp = 0; n_fail = 0; n_deliv = 0; cyc = 0; last_due = 0; lat_cfg = 1;
    model_pc = RST_PC; prev_stall = 1'b0; prev_addr = '0; last_acc_addr = '0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; dec_ready = 1'b0;

    // Reset values, then free run with single-cycle memory.
    #12;
    check("init_req_valid", 32'(imem_req_valid), 32'd0);
    check("init_req_addr", imem_req_addr, RST_PC);
    check("init_dec_valid", 32'(dec_valid), 32'd0);
    check("init_dec_pc", dec_pc, 32'd0);
    check("init_dec_inst", dec_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    first_acc = -1; first_dv = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);
      if (i == 0) begin
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RST_PC);
      end
      if (acc && first_acc < 0) first_acc = i;
      if (dv && first_dv < 0) first_dv = i;
    end
    check("first_dec_latency", 32'(first_dv - first_acc), 32'd2);
    check("run_progress", 32'(n_deliv >= 8), 32'd1);

    // Asynchronous reset while decode holds a valid instruction.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 32'd0, 1'b1, 1'b0, dr, dv, acc);
      found = dv;
    end
    check("pre_reset_dec_valid", 32'(dec_valid), 32'd1);
    do_reset();

    // Back-pressure: decode stalled for 10 cycles.
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 32'd0, 1'b1, 1'b0, dr, dv, acc);
      if (acc) n_acc++;
    end
    check("bp_accepts", 32'(n_acc), 32'd2);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_dec_valid", 32'(dec_valid), 32'd1);
    check("bp_dec_pc", dec_pc, RST_PC);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);
      if (acc && !found) begin
        found = 1'b1;
        check("bp_resume_addr", last_acc_addr, RST_PC + 32'd8);
      end
    end
    check("bp_resumed", 32'(found), 32'd1);

    // Redirect with two requests in flight, memory latency 3.
    for (int i = 0; i < 8; i++) step(0, 32'd0, 1'b0, 1'b1, dr, dv, acc);
    check("drain_a", 32'(exp_q.size()), 32'd0);
    lat_cfg = 3;
    n_acc = 0;
    for (int i = 0; i < 2; i++) begin
      step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);
      if (acc) n_acc++;
    end
    check("inflight_accepts", 32'(n_acc), 32'd2);
    step(1, 32'h0000_2002, 1'b1, 1'b1, dr, dv, acc);
    fk = -1;
    for (int k = 1; k <= 20 && fk < 0; k++) begin
      step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);
      if (k == 1) check("redir_dec_valid_next", 32'(dv), 32'd0);
      if (dv) begin
        fk = k;
        check("redir_first_pc", dec_pc, 32'h0000_2000);
      end
    end
    check("redir_first_latency_ok", 32'(fk >= 3), 32'd1);
    for (int i = 0; i < 15; i++) step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);

    // Redirect coincident with a response and a dequeue.
    lat_cfg = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(2, 32'h0000_3000, 1'b1, 1'b1, dr, dv, acc);
      found = dr;
    end
    check("coincident_found", 32'(found), 32'd1);
    step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);
    check("coincident_dec_valid_next", 32'(dv), 32'd0);
    base = n_deliv;
    for (int i = 0; i < 12; i++) step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);
    check("coincident_progress", 32'(n_deliv - base >= 3), 32'd1);

    // Address wrap at the top of the address space.
    for (int i = 0; i < 8; i++) step(0, 32'd0, 1'b0, 1'b1, dr, dv, acc);
    step(1, 32'hFFFF_FFF8, 1'b0, 1'b1, dr, dv, acc);
    step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);
    check("wrap_req_valid", 32'(acc), 32'd1);
    check("wrap_req_addr", last_acc_addr, 32'hFFFF_FFF8);
    base = n_deliv;
    for (int i = 0; i < 12; i++) step(0, 32'd0, 1'b1, 1'b1, dr, dv, acc);
    check("wrap_progress", 32'(n_deliv - base >= 3), 32'd1);

    // Random traffic: ready, stalls, latency and redirects.
    lat_cfg = 0;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(($urandom_range(0, 19) == 0) ? 1 : 0, rpc,
           $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, dr, dv, acc);
    end

    // Drain: everything accepted in the current epoch must reach decode.
    for (int i = 0; i < 40 && (exp_q.size() != 0 || pend_q.size() != 0); i++) begin
      step(0, 32'd0, 1'b0, 1'b1, dr, dv, acc);
    end
    step(0, 32'd0, 1'b0, 1'b1, dr, dv, acc);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
